mem64_port_arbiter: RTL and testbench
=====================================

// Module: mem64_port_arbiter
// PURPOSE
//  2:1 round-robin arbiter in front of mem64_bram_ip; shares the 64-bit burst port between
//  the L1 data cache (port 0) and a second line requester (port 1, I-side/DMA).
//  Burst-locked: grant holds for a full BURST_LEN-beat line, then passes to the other port.
//  Requesters see the same req/wr/addr/wdata/ready/rvalid/rdata protocol as the raw memory.
// PARAMETERS
//  ADDR_BITS  16  byte address width, passed through to memory
//  DATA_W     64  beat width
//  BURST_LEN  8   beats per line transfer; power of 2, >=2
// PORTS
//  clk        in   1          single clock; all state changes on posedge
//  rst        in   1          synchronous, active-high reset
//  rN_req     in   1          N=0,1: burst request; held high for the whole burst
//  rN_wr      in   1          1=writeback burst, 0=line load; stable while rN_req=1
//  rN_addr    in   ADDR_BITS  line base address; stable while rN_req=1
//  rN_wdata   in   DATA_W     write beat data
//  rN_ready   out  1          write beat accepted (mem_ready routed to owner)
//  rN_rvalid  out  1          read beat valid (mem_rvalid routed to owner)
//  rN_rdata   out  DATA_W     read beat data (mem_rdata, broadcast to both)
//  rN_gnt     out  1          port N owns the memory this cycle
//  mem_req/mem_wr/mem_addr/mem_wdata  out  1/1/ADDR_BITS/DATA_W  to memory
//  mem_ready/mem_rvalid/mem_rdata     in   1/1/DATA_W            from memory
// BEHAVIOUR
//  - Reset: state=IDLE, rN_gnt=0, mem_req=0, mem_wr=0, beat=0, rr_ptr=0 (port 0 favoured).
//  - States: IDLE -> BUSY (grant) -> IDLE. One registered owner bit, 3-bit beat counter.
//  - IDLE: rN_req sampled; one req -> grant it; both -> grant port rr_ptr. Grant registered:
//    rN_gnt and mem_req rise 1 cycle after rN_req first seen (arbitration latency 1 clk).
//  - BUSY: mem_req=owner_req; mem_wr/mem_addr/mem_wdata combinationally muxed from owner.
//    Non-owner: rN_ready=0, rN_rvalid=0. Owner: rN_ready=mem_ready, rN_rvalid=mem_rvalid.
//  - Beat complete = mem_req & (mem_wr ? mem_ready : mem_rvalid); counter +1 per beat.
//  - Last beat (beat==BURST_LEN-1 & beat complete): -> IDLE, beat=0, rr_ptr=~owner.
//    IDLE lasts >=1 clk, so a requester re-asserting at once still yields to a waiting peer.
//  - Owner drops rN_req mid-burst: abort -> IDLE next clk, beat=0, rr_ptr=~owner; mem_req low.
//  - Non-owner request during BUSY: held pending, never dropped; max wait = 1 burst + 2 clk.
//  - mem_addr/mem_wdata in IDLE: drive 0; mem_wr=0.
//  - Reset in BUSY: immediate IDLE state on same edge; no beat forwarded after reset edge.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs stat_gnt0, stat_gnt1, stat_conflict (16-bit each):
//   +1 per grant to port 0/1, +1 per IDLE cycle with both req high; saturate at 16'hFFFF;
//   cleared by rst. Undefined: ports and counters absent, behaviour otherwise identical.
// TESTING
//  T1 reset: rst=1 2 clk with r0_req=r1_req=1 -> mem_req=0, gnt=0; rst low -> r0_gnt 1 clk later.
//  T2 r0 load only, addr 16'h1240 -> mem_req@+1, mem_addr=16'h1240, 8 rvalid beats to r0; r1_rvalid=0.
//  T3 r0,r1 req same clk after reset -> r0 8 beats, IDLE 1 clk, r1 granted; next tie -> r0 wins.
//  T4 r0 writeback 16'hA000 with mem_ready stalls every other clk -> exactly 8 beats, wdata order 0..7.
//  T5 r1 drops req after 3 beats -> IDLE next clk, beat=0, waiting r0 granted next.
//  T6 ARB_STATS_EN: 3 contested bursts -> stat_conflict=3, stat_gnt0+stat_gnt1=6; no-macro build elaborates.

Source files
------------

// File: rtl/mem64_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem64_port_arbiter
//
// Purpose:
//   2:1 round-robin arbiter that shares the 64-bit burst port of
//   mem64_bram_ip between the L1 data cache (port 0) and a second line
//   requester (port 1, I-side or DMA). Once a port is granted it keeps the
//   memory for a whole BURST_LEN-beat line. The grant then passes to the
//   other port if that port is waiting. Each requester sees the same
//   req/wr/addr/wdata/ready/rvalid/rdata protocol as the raw memory.
//
// Parameters:
//   ADDR_BITS  byte address width passed through to memory (default 16)
//   DATA_W     beat width (default 64)
//   BURST_LEN  beats per line transfer, power of 2, >= 2 (default 8)
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   rN_req/wr/addr/wdata     requester N inputs (N = 0, 1)
//   rN_ready/rvalid/rdata    requester N beat handshakes and read data
//   rN_gnt                   port N owns the memory this cycle
//   mem_req/wr/addr/wdata    to memory
//   mem_ready/rvalid/rdata   from memory
//
// Configuration:
//   ARB_STATS_EN  when defined, adds saturating 16-bit counters:
//                 stat_gnt0, stat_gnt1 and stat_conflict.
// ----------------------------------------------------------------------------
module mem64_port_arbiter #(
   parameter int ADDR_BITS = 16,
   parameter int DATA_W    = 64,
   parameter int BURST_LEN = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 r0_req,
   input  logic                 r0_wr,
   input  logic [ADDR_BITS-1:0] r0_addr,
   input  logic [DATA_W-1:0]    r0_wdata,
   output logic                 r0_ready,
   output logic                 r0_rvalid,
   output logic [DATA_W-1:0]    r0_rdata,
   output logic                 r0_gnt,
   input  logic                 r1_req,
   input  logic                 r1_wr,
   input  logic [ADDR_BITS-1:0] r1_addr,
   input  logic [DATA_W-1:0]    r1_wdata,
   output logic                 r1_ready,
   output logic                 r1_rvalid,
   output logic [DATA_W-1:0]    r1_rdata,
   output logic                 r1_gnt,
   output logic                 mem_req,
   output logic                 mem_wr,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic                 mem_ready,
   input  logic                 mem_rvalid,
   input  logic [DATA_W-1:0]    mem_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]          stat_gnt0,
   output logic [15:0]          stat_gnt1,
   output logic [15:0]          stat_conflict
`endif
);

   localparam int BEAT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   logic              state;
   logic              owner;
   logic              rr_ptr;
   logic [BEAT_W-1:0] beat;

   logic                 busy;
   logic                 owner_req;
   logic                 owner_wr;
   logic [ADDR_BITS-1:0] owner_addr;
   logic [DATA_W-1:0]    owner_wdata;
   logic                 beat_done;
   logic                 any_req;
   logic                 pick;

   assign busy        = (state == ST_BUSY);
   assign owner_req   = owner ? r1_req   : r0_req;
   assign owner_wr    = owner ? r1_wr    : r0_wr;
   assign owner_addr  = owner ? r1_addr  : r0_addr;
   assign owner_wdata = owner ? r1_wdata : r0_wdata;

   // When both ports ask at once the round-robin pointer breaks the tie;
   // otherwise the single requester wins.
   assign any_req = r0_req | r1_req;
   assign pick    = (r0_req & r1_req) ? rr_ptr : r1_req;

   // Memory side only sees the owner's request while busy. In IDLE every
   // outgoing field is zero so the memory never sees a stale address.
   assign mem_req   = busy & owner_req;
   assign mem_wr    = busy & owner_wr;
   assign mem_addr  = busy ? owner_addr  : '0;
   assign mem_wdata = busy ? owner_wdata : '0;

   // A beat counts only on the handshake that matches the burst direction.
   assign beat_done = mem_req & (mem_wr ? mem_ready : mem_rvalid);

   assign r0_gnt    = busy & ~owner;
   assign r1_gnt    = busy &  owner;
   assign r0_ready  = r0_gnt & mem_ready;
   assign r1_ready  = r1_gnt & mem_ready;
   assign r0_rvalid = r0_gnt & mem_rvalid;
   assign r1_rvalid = r1_gnt & mem_rvalid;
   assign r0_rdata  = mem_rdata;
   assign r1_rdata  = mem_rdata;

   // Arbitration FSM. IDLE always lasts at least one clock. This gives a
   // waiting peer its turn even if the previous owner re-requests at once.
   // Both a completed line and an owner abort hand priority to the other port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         owner  <= 1'b0;
         rr_ptr <= 1'b0;
         beat   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state <= ST_BUSY;
                  owner <= pick;
                  beat  <= '0;
               end
            end
            ST_BUSY: begin
               if (!owner_req) begin
                  state  <= ST_IDLE;
                  beat   <= '0;
                  rr_ptr <= ~owner;
               end else if (beat_done) begin
                  if (beat == LAST_BEAT) begin
                     state  <= ST_IDLE;
                     beat   <= '0;
                     rr_ptr <= ~owner;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ARB_STATS_EN
   // Grant counters bump on the IDLE edge that issues the grant. The
   // conflict counter bumps on every IDLE cycle in which both ports ask.
   // All three counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_gnt0     <= '0;
         stat_gnt1     <= '0;
         stat_conflict <= '0;
      end else if (!busy) begin
         if (any_req && !pick && stat_gnt0 != 16'hFFFF)
            stat_gnt0 <= stat_gnt0 + 16'd1;
         if (any_req && pick && stat_gnt1 != 16'hFFFF)
            stat_gnt1 <= stat_gnt1 + 16'd1;
         if (r0_req && r1_req && stat_conflict != 16'hFFFF)
            stat_conflict <= stat_conflict + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem64_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem64_port_arbiter
//
// Purpose:
//   Self-checking bench for mem64_port_arbiter. A simple memory responder
//   answers the arbiter's memory port, with optional stalls. Each line
//   transfer is described as a vector: which ports request, in which
//   direction, where an abort happens, and which owner and beat count
//   result. A table covers the fixed cases. Random vectors take their
//   expected owner from a round-robin model kept here. Hand-written
//   sequences cover reset, back-to-back ties, mid-burst abort and reset
//   during a burst.
//
// Ports: none (top-level bench). Define ARB_STATS_EN to also check counters.
// ----------------------------------------------------------------------------
module tb_mem64_port_arbiter;

   logic        clk;
   logic        rst;
   logic        r0_req, r0_wr, r1_req, r1_wr;
   logic [15:0] r0_addr, r1_addr;
   logic [63:0] r0_wdata, r1_wdata;
   logic        r0_ready, r0_rvalid, r0_gnt;
   logic        r1_ready, r1_rvalid, r1_gnt;
   logic [63:0] r0_rdata, r1_rdata;
   logic        mem_req, mem_wr, mem_ready, mem_rvalid;
   logic [15:0] mem_addr;
   logic [63:0] mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
   logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

   logic        allow;
   logic [63:0] mrdata;

   int checks = 0;
   int errors = 0;

   // Round-robin and statistics model state
   bit mrr;
   int exp_g0, exp_g1, exp_conf;

   typedef struct {
      bit          r0;
      bit          r1;
      bit          wr0;
      bit          wr1;
      logic [15:0] a0;
      logic [15:0] a1;
      int          abort_at;
      int          stall;
      bit          exp_owner;
      int          exp_beats;
   } vec_t;

   vec_t tbl [8];

   mem64_port_arbiter dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_gnt(r0_gnt),
      .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_gnt(r1_gnt),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
      , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
   );

   // Memory responder: answers whatever direction is requested when allowed.
   assign mem_ready  = mem_req &  mem_wr & allow;
   assign mem_rvalid = mem_req & ~mem_wr & allow;
   assign mem_rdata  = mrdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit so a stuck DUT cannot hang the run.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      r0_req = 1'b0;
      r1_req = 1'b0;
      allow = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mrr = 1'b0;
   endtask

   // Applies one line transfer described by v and checks grant, muxing,
   // beat routing, data and the final beat count.
   task automatic apply_stimulus(input vec_t v);
      int          beats;
      int          cyc;
      bit          own;
      bit          wr;
      logic [63:0] pat0, pat1;
      logic        own_hs, oth_hs;
      own  = v.exp_owner;
      wr   = own ? v.wr1 : v.wr0;
      pat0 = {$urandom, $urandom};
      pat1 = {$urandom, $urandom};
      @(negedge clk);
      r0_req = v.r0;  r1_req = v.r1;
      r0_wr  = v.wr0; r1_wr  = v.wr1;
      r0_addr = v.a0; r1_addr = v.a1;
      r0_wdata = pat0; r1_wdata = pat1;
      allow = 1'b1;
      if (v.r0 && v.r1) exp_conf++;
      if (own) exp_g1++; else exp_g0++;
      @(posedge clk);
      #1;
      check_output("gnt0", r0_gnt, own == 1'b0);
      check_output("gnt1", r1_gnt, own == 1'b1);
      check_output("mem_req_grant", mem_req, 1'b1);
      check_output("mem_addr", mem_addr, own ? v.a1 : v.a0);
      check_output("mem_wr", mem_wr, wr);
      beats = 0;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!(own ? r1_gnt : r0_gnt)) break;
         cyc++;
         if (cyc > 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL burst_timeout: got %0d beats after %0d clk", beats, cyc);
            break;
         end
         if (own) r1_wdata = pat1 + 64'(beats);
         else     r0_wdata = pat0 + 64'(beats);
         mrdata = {$urandom, $urandom};
         case (v.stall)
            0:       allow = 1'b1;
            1:       allow = (cyc % 2) == 1;
            default: allow = 1'($urandom_range(0, 1));
         endcase
         if (beats == v.abort_at) begin
            if (own) r1_req = 1'b0; else r0_req = 1'b0;
         end
         #1;
         own_hs = own ? (wr ? r1_ready : r1_rvalid) : (wr ? r0_ready : r0_rvalid);
         oth_hs = own ? (r0_ready | r0_rvalid) : (r1_ready | r1_rvalid);
         check_output("other_port_quiet", oth_hs, 1'b0);
         if (own_hs) begin
            if (wr) check_output("wdata_order", mem_wdata,
                                 (own ? pat1 : pat0) + 64'(beats));
            else    check_output("rdata", own ? r1_rdata : r0_rdata, mrdata);
            beats++;
         end
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      allow = 1'b1;
      check_output("idle_mem_req", mem_req, 1'b0);
      check_output("idle_mem_addr", mem_addr, 16'h0);
      check_output("beats", beats, v.exp_beats);
      mrr = ~own;
   endtask

   initial begin
      int   cnt;
      vec_t rv;
      rst = 1'b1;
      r0_req = 0; r1_req = 0; r0_wr = 0; r1_wr = 0;
      r0_addr = 0; r1_addr = 0; r0_wdata = 0; r1_wdata = 0;
      allow = 1'b1;
      mrdata = '0;
      exp_g0 = 0; exp_g1 = 0; exp_conf = 0;

      //          r0 r1 w0 w1  a0        a1     abort stall own beats
      tbl[0] = '{1, 0, 0, 0, 16'h1240, 16'h0000, 8, 0, 0, 8};
      tbl[1] = '{1, 0, 1, 0, 16'hA000, 16'h0000, 8, 1, 0, 8};
      tbl[2] = '{1, 1, 0, 1, 16'h2000, 16'h3040, 8, 0, 1, 8};
      tbl[3] = '{1, 1, 1, 0, 16'h4080, 16'h50C0, 8, 2, 0, 8};
      tbl[4] = '{0, 1, 0, 0, 16'h0000, 16'h6100, 3, 0, 1, 3};
      tbl[5] = '{1, 1, 0, 0, 16'h7140, 16'h8180, 5, 2, 0, 5};
      tbl[6] = '{0, 1, 0, 1, 16'h0000, 16'h91C0, 8, 1, 1, 8};
      tbl[7] = '{1, 1, 1, 1, 16'hB200, 16'hC240, 8, 2, 0, 8};

      do_reset();
      check_output("reset_gnt0", r0_gnt, 1'b0);
      check_output("reset_mem_req", mem_req, 1'b0);

      for (int i = 0; i < 8; i++) apply_stimulus(tbl[i]);

      // Random line transfers; the owner comes from the round-robin rule.
      for (int i = 0; i < 40; i++) begin
         rv.r0  = 1'($urandom_range(0, 1));
         rv.r1  = rv.r0 ? 1'($urandom_range(0, 1)) : 1'b1;
         rv.wr0 = 1'($urandom_range(0, 1));
         rv.wr1 = 1'($urandom_range(0, 1));
         rv.a0  = 16'($urandom) & 16'hFFC0;
         rv.a1  = 16'($urandom) & 16'hFFC0;
         rv.abort_at  = $urandom_range(1, 8);
         rv.stall     = $urandom_range(0, 2);
         rv.exp_owner = (rv.r0 && rv.r1) ? mrr : rv.r1;
         rv.exp_beats = rv.abort_at;
         apply_stimulus(rv);
      end

`ifdef ARB_STATS_EN
      check_output("stat_gnt0", stat_gnt0, 16'(exp_g0));
      check_output("stat_gnt1", stat_gnt1, 16'(exp_g1));
      check_output("stat_conflict", stat_conflict, 16'(exp_conf));
`endif

      // Reset held with both ports requesting: nothing granted until release.
      @(negedge clk);
      rst = 1'b1; r0_req = 1'b1; r1_req = 1'b1; r0_wr = 1'b0; r1_wr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_output("t1_mem_req", mem_req, 1'b0);
      check_output("t1_gnt", {r0_gnt, r1_gnt}, 2'b00);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_output("t1_gnt_after", {r0_gnt, r1_gnt}, 2'b10);
`ifdef ARB_STATS_EN
      check_output("t1_stat_cleared", stat_gnt1, 16'h0);
`endif
      r0_req = 1'b0; r1_req = 1'b0;
      do_reset();

      // Both ports held: r0 line, one IDLE clk, r1 line, IDLE, r0 again.
      @(negedge clk);
      r0_req = 1'b1; r1_req = 1'b1; r0_wr = 1'b0; r1_wr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_output("t3_r0_owns", {r0_gnt, r0_rvalid, r1_rvalid}, 3'b110);
      end
      @(negedge clk);
      check_output("t3_idle1", {r0_gnt, r1_gnt}, 2'b00);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_output("t3_r1_owns", {r1_gnt, r1_rvalid, r0_rvalid}, 3'b110);
      end
      @(negedge clk);
      check_output("t3_idle2", {r0_gnt, r1_gnt}, 2'b00);
      @(negedge clk);
      check_output("t3_tie_r0", {r0_gnt, r1_gnt}, 2'b10);
      r0_req = 1'b0; r1_req = 1'b0;
      do_reset();

      // r1 aborts after 3 beats while r0 waits; r0 then gets a full line.
      @(negedge clk);
      r1_req = 1'b1; r1_wr = 1'b0; r0_wr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         r0_req = 1'b1;
         check_output("t5_r1_beat", {r1_gnt, r1_rvalid}, 2'b11);
      end
      @(negedge clk);
      r1_req = 1'b0;
      #1;
      check_output("t5_abort_mem_req", mem_req, 1'b0);
      check_output("t5_abort_rvalid", r1_rvalid, 1'b0);
      @(negedge clk);
      check_output("t5_idle", {r0_gnt, r1_gnt}, 2'b00);
      @(negedge clk);
      check_output("t5_r0_gnt", {r0_gnt, r1_gnt}, 2'b10);
      cnt = 0;
      for (int i = 0; i < 50 && r0_gnt; i++) begin
         if (r0_rvalid) cnt++;
         @(negedge clk);
      end
      check_output("t5_r0_beats", cnt, 8);
      r0_req = 1'b0;
      do_reset();

      // Reset during a burst: grant and beats stop on the reset edge.
      @(negedge clk);
      r0_req = 1'b1; r0_wr = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rb_busy", r0_gnt, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_output("rb_gnt", r0_gnt, 1'b0);
      check_output("rb_mem_req", mem_req, 1'b0);
      check_output("rb_rvalid", r0_rvalid, 1'b0);
      @(negedge clk);
      r0_req = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
